blink_controller: RTL and testbench



---
 rtl/blink_pkg.sv | 11 +
 rtl/blink_controller_tick_gen.sv | 33 +++
 rtl/blink_controller.sv | 77 +++++++
 tb/tb_blink_controller.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared definitions for the LED blink controller.
// Provides default clock/tick rates, the speed field width and its type.
package blink_pkg;

  localparam int unsigned DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int unsigned DEF_TICK_HZ     = 1_000;

  localparam int unsigned SPEED_W = 16;
  typedef logic [SPEED_W-1:0] speed_t;

endpackage

// File: rtl/blink_controller_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every CYCLES_PER_TICK clocks.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   tick - high for the single cycle in which the prescaler holds its last count
module tick_gen
  import blink_pkg::*;
#(
  parameter int unsigned CYCLES_PER_TICK = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = (CYCLES_PER_TICK > 2) ? $clog2(CYCLES_PER_TICK) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CYCLES_PER_TICK - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CYCLES_PER_TICK - 2);

  logic [CNT_W-1:0] cnt;

  // tick is registered one count early so it is high exactly while cnt == LAST
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == PRE_LAST);
    end
  end

endmodule

// File: rtl/blink_controller.sv
// LED square-wave generator: toggles led every `speed` milliseconds.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   speed - half-period in ms, 0 disables blinking (led held low)
//   led   - registered LED drive, active-high
// Optional build macro BLINK_CTRL_SPEED_REG_EN: when defined, speed is captured
// at the start of each half-period so changes never alter one in progress.
module blink_controller
  import blink_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int unsigned TICK_HZ     = DEF_TICK_HZ
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] speed,
  output logic               led
);

  localparam int unsigned CYCLES_PER_TICK = (TICK_HZ == 0) ? 0 : CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned TICK_REM        = (TICK_HZ == 0) ? 1 : CLK_FREQ_HZ % TICK_HZ;

  if (TICK_HZ == 0 || CYCLES_PER_TICK < 2 || TICK_REM != 0) begin : g_bad_cfg
    $error("blink_controller: CLK_FREQ_HZ must be an exact multiple (>= 2x) of TICK_HZ");
  end

  logic   tick;
  logic   hit;
  speed_t speed_eff;
  speed_t ms_cnt;

  tick_gen #(
    .CYCLES_PER_TICK(CYCLES_PER_TICK)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // >= (not ==) so a speed reduction mid-count toggles on the next tick
  assign hit = tick && (speed_eff != '0) && (ms_cnt >= speed_eff - speed_t'(1));

`ifdef BLINK_CTRL_SPEED_REG_EN
  speed_t speed_q;

  // Recapture on every tick while disabled so a newly enabled speed is picked up
  always_ff @(posedge clk) begin
    if (rst) begin
      speed_q <= '0;
    end else if (tick && ((speed_q == '0) || hit)) begin
      speed_q <= speed;
    end
  end

  assign speed_eff = speed_q;
`else
  assign speed_eff = speed;
`endif

  // Millisecond counter and LED register
  always_ff @(posedge clk) begin
    if (rst) begin
      led    <= 1'b0;
      ms_cnt <= '0;
    end else if (speed_eff == '0) begin
      led    <= 1'b0;
      ms_cnt <= '0;
    end else if (hit) begin
      led    <= ~led;
      ms_cnt <= '0;
    end else if (tick) begin
      ms_cnt <= ms_cnt + speed_t'(1);
    end
  end

endmodule

// File: tb/tb_blink_controller.sv
module tb_blink_controller;
  import blink_pkg::*;

  localparam int CPT = 10;
`ifdef BLINK_CTRL_SPEED_REG_EN
  localparam int EXTRA = CPT;  // first tick after enable only captures speed
`else
  localparam int EXTRA = 0;
`endif

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic [15:0] speed   = 16'd3;
  logic        led;
  logic        rst_d   = 1'b1;
  logic [15:0] speed_d = 16'd5;
  logic        led_d;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  blink_controller #(
    .CLK_FREQ_HZ(10_000),
    .TICK_HZ    (1_000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .speed(speed),
    .led  (led)
  );

  blink_controller dut_def (
    .clk  (clk),
    .rst  (rst_d),
    .speed(speed_d),
    .led  (led_d)
  );

  // Reference model: time since reset in clocks, a tick every CPT clocks,
  // and the LED flips once `speed` ticks have elapsed since the last flip.
  int   since_rst = 0;
  int   m_elapsed = 0;
  int   m_hp      = 0;
  logic m_led     = 1'b0;
  bit   m_valid   = 1'b0;

  always @(posedge clk) begin
    bit is_tick;
    if (rst) begin
      since_rst = 0;
      m_elapsed = 0;
      m_hp      = 0;
      m_led     = 1'b0;
      m_valid   = 1'b1;
    end else begin
      since_rst++;
      is_tick = (since_rst % CPT) == 0;
`ifdef BLINK_CTRL_SPEED_REG_EN
      if (m_hp == 0) begin
        m_led     = 1'b0;
        m_elapsed = 0;
        if (is_tick) m_hp = int'(speed);
      end else if (is_tick) begin
        m_elapsed++;
        if (m_elapsed >= m_hp) begin
          m_led     = ~m_led;
          m_elapsed = 0;
          m_hp      = int'(speed);
        end
      end
`else
      if (speed == 16'd0) begin
        m_led     = 1'b0;
        m_elapsed = 0;
      end else if (is_tick) begin
        m_elapsed++;
        if (m_elapsed >= int'(speed)) begin
          m_led     = ~m_led;
          m_elapsed = 0;
        end
      end
`endif
    end
  end

  // Scoreboard and toggle recorder, sampled 2 time units after each rising edge
  int   tog_q[$];
  logic led_prev = 1'b0;
  int   d_edges  = 0;
  logic led_d_prev = 1'b0;

  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      n_checks++;
      if (led !== m_led) begin
        n_errors++;
        $display("FAIL scoreboard t=%0t: led=%b expected %b", $time, led, m_led);
      end
      if (led !== led_prev) tog_q.push_back(since_rst);
      led_prev = led;
    end
    if (!rst_d) begin
      if (led_d !== led_d_prev) d_edges++;
      led_d_prev = led_d;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_toggles(input string name, input int exp[$]);
    check({name, "_count"}, 32'(tog_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < tog_q.size(); i++)
      check({name, "_edge"}, 32'(tog_q[i]), 32'(exp[i]));
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst = 1'b1;
    run(ncyc);
    rst = 1'b0;
    tog_q.delete();
  endtask

  typedef struct {
    logic        rst;
    logic [15:0] speed;
    int          cycles;
    logic        exp_led;
    int          exp_tog;
  } vec_t;

  vec_t tbl[7];

  // Defaults instance: 1 ms = 100_000 clocks, so no edge within this run
  initial begin
    rst_d = 1'b1;
    run(2);
    check("def_led_in_reset", 32'(led_d), 32'd0);
    rst_d = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_l;
    int eq[$];
    int r;

    // Continuous sequence from reset with CPT=10
`ifdef BLINK_CTRL_SPEED_REG_EN
    tbl[0] = '{1'b1, 16'd3, 2,  1'b0, 0};
    tbl[1] = '{1'b0, 16'd3, 35, 1'b0, 0};
    tbl[2] = '{1'b0, 16'd3, 30, 1'b1, 1};
    tbl[3] = '{1'b0, 16'd0, 5,  1'b0, 1};
    tbl[4] = '{1'b0, 16'd1, 25, 1'b1, 1};
    tbl[5] = '{1'b0, 16'd2, 30, 1'b1, 2};
    tbl[6] = '{1'b0, 16'd0, 3,  1'b1, 0};
`else
    tbl[0] = '{1'b1, 16'd3, 2,  1'b0, 0};
    tbl[1] = '{1'b0, 16'd3, 35, 1'b1, 1};
    tbl[2] = '{1'b0, 16'd3, 30, 1'b0, 1};
    tbl[3] = '{1'b0, 16'd0, 5,  1'b0, 0};
    tbl[4] = '{1'b0, 16'd1, 25, 1'b0, 2};
    tbl[5] = '{1'b0, 16'd2, 30, 1'b1, 1};
    tbl[6] = '{1'b0, 16'd0, 3,  1'b0, 1};
`endif
    for (int i = 0; i < 7; i++) begin
      rst   = tbl[i].rst;
      speed = tbl[i].speed;
      tog_q.delete();
      run(tbl[i].cycles);
      check($sformatf("table%0d_led", i), 32'(led), 32'(tbl[i].exp_led));
      check($sformatf("table%0d_toggles", i), 32'(tog_q.size()), 32'(tbl[i].exp_tog));
    end

    // speed=1: toggle every tick
    speed = 16'd1;
    do_reset(2);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      exp_l = (n < CPT + EXTRA) ? 0 : ((n - EXTRA) / CPT) % 2;
      check("speed1_led", 32'(led), 32'(exp_l));
    end

    // speed=0 holds led low, then enabling with speed=3
    speed = 16'd0;
    do_reset(2);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      check("speed0_led", 32'(led), 32'd0);
    end
    speed = 16'd3;
    run(40);
    eq = '{230 + EXTRA};
    check_toggles("enable3", eq);

    // speed 8 -> 2 while ms_cnt = 5
    speed = 16'd8;
    do_reset(2);
    run(52 + EXTRA);
    check("reduce_before", 32'(tog_q.size()), 32'd0);
    speed = 16'd2;
    run(105 + 3 * EXTRA - 52 - EXTRA);
`ifdef BLINK_CTRL_SPEED_REG_EN
    eq = '{90, 110, 130};
`else
    eq = '{60, 80, 100};
`endif
    check_toggles("reduce", eq);

    // Reset pulse while led is high
    speed = 16'd4;
    do_reset(2);
    run(45 + EXTRA);
    check("midrst_led_high", 32'(led), 32'd1);
    rst = 1'b1;
    run(1);
    check("midrst_led_low", 32'(led), 32'd0);
    rst = 1'b0;
    tog_q.delete();
    run(50);
    eq = '{40 + EXTRA};
    check_toggles("midrst_rise", eq);

    // Maximum speed: nothing for a long while, then a reduction takes hold
    speed = 16'hFFFF;
    do_reset(2);
    run(3000);
    check("ffff_no_toggle", 32'(tog_q.size()), 32'd0);
    speed = 16'd2;
    run(20);
`ifdef BLINK_CTRL_SPEED_REG_EN
    eq = {};
`else
    eq = '{3010};
`endif
    check_toggles("ffff_reduce", eq);

    // Randomized speeds and reset pulses against the reference model
    do_reset(2);
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        rst = 1'b1;
        run(1);
        rst = 1'b0;
      end else begin
        if (r < 3)       speed = 16'd0;
        else if (r == 3) speed = 16'hFFFF;
        else             speed = 16'($urandom_range(1, 6));
        run(int'($urandom_range(1, 60)));
      end
    end

    check("def_led_end", 32'(led_d), 32'd0);
    check("def_edges_end", 32'(d_edges), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
